branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter PC_W, default 16: program counter width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 id_valid  input  1  decode stage presents a valid instruction this cycle.
REQ-005 id_op  input  4  opcode of the decoded instruction, using the same encoding as the comparator cmp field.
REQ-006 id_pc  input  PC_W  address of the decoded instruction.
REQ-007 id_off  input  8  signed two's-complement branch displacement.
REQ-008 jmp_tgt  input  PC_W  absolute jump target, taken from operand rd1.
REQ-009 br  input  1  comparator branch-condition result for the current id_op, valid in the same cycle.
REQ-010 stall  input  1  pipeline hold request.
REQ-011 pc  output  PC_W  fetch address.
REQ-012 if_en  output  1  fetch enable.
REQ-013 flush  output  1  squash the younger instructions in IF and ID.
REQ-014 busy  output  1  high whenever state != RUN.
REQ-015 tkn_cnt  output  16  saturating count of taken redirects.

Function
REQ-016 Opcodes 4'b0100, 4'b0101 and 4'b0110 SHALL be conditional branches, 4'b1100 SHALL be an unconditional jump, 4'b0000 SHALL be halt, and all others SHALL be non-control.
REQ-017 State machine: RUN, FLUSH, HALT; flush-length counter 2 bits.
REQ-018 In RUN with stall=0, pc SHALL advance to pc+1 each cycle, modulo 2^PC_W (16'hFFFF wraps to 16'h0000).
REQ-019 In RUN with stall=0, a taken branch (id_valid & branch opcode & br) SHALL load pc with id_pc + 1 + sign-extended id_off, modulo 2^PC_W, on the next edge.
REQ-020 In RUN with stall=0, a jump (id_valid & opcode 1100) SHALL load pc with jmp_tgt on the next edge, regardless of br.
REQ-021 A not-taken branch SHALL behave exactly as a non-control instruction.
REQ-022 A redirect SHALL move the FSM to FLUSH; flush SHALL be registered and high for exactly 2 cycles starting the cycle after the decision; the FSM SHALL then return to RUN.
REQ-023 During FLUSH, id_valid SHALL be ignored, pc SHALL still advance by 1 per cycle, and stall SHALL be ignored.
REQ-024 stall=1 in RUN SHALL hold pc, the state and tkn_cnt; a branch or jump SHALL be decided only in a cycle with stall=0.
REQ-025 Halt (id_valid & opcode 0000, stall=0) SHALL enter HALT next cycle; in HALT, if_en=0, pc is held, and only reset exits.
REQ-026 Each redirect SHALL increment tkn_cnt by 1, saturating at 16'hFFFF.
REQ-027 if_en SHALL be 1 in RUN and FLUSH, and 0 in HALT.
REQ-028 Decision latency from the input cycle to the pc update SHALL be 1 cycle, with no combinational path from br to pc.

Reset
REQ-029 While rst_n=0: pc=0, flush=0, busy=0, tkn_cnt=0, if_en=0, state=RUN, counter=0; the asynchronous assertion SHALL clear all of these even mid-FLUSH.
REQ-030 The first rising edge after rst_n deasserts SHALL set if_en=1 with pc=0 fetched.

Structure
REQ-031 A shared package cups_pkg SHALL hold the opcode constants (OP_BLT, OP_BGT, OP_BEQ, OP_JMP, OP_HALT), the state typedef, and the PC_W default.
REQ-032 There SHALL be no sub-module; the comparator stays outside, with br driven in by the integrator.

Verification
REQ-033 Reset, then 5 idle cycles -> pc goes 0,1,2,3,4; flush=0; tkn_cnt=0.
REQ-034 id_op=0101, br=1, id_pc=16'h0010, id_off=8'hFE -> next pc=16'h000F; flush high 2 cycles; tkn_cnt=1.
REQ-035 id_op=0110, br=0 -> pc increments; flush stays 0; tkn_cnt unchanged.
REQ-036 Jump with jmp_tgt=16'h1234 while stall=1 for 3 cycles -> pc held; redirect occurs only on the first stall=0 cycle.
REQ-037 pc=16'hFFFF, no branch -> pc=16'h0000; opcode 0000 -> HALT with if_en=0 and pc frozen.
REQ-038 rst_n pulsed low during the second FLUSH cycle -> flush=0 and pc=0 immediately.

Source files
------------

// File: rtl/cups_pkg.sv
// Shared branch-control definitions: opcode encodings, controller states, default PC width.
package cups_pkg;

   localparam int PC_W_DEF = 16;

   localparam logic [3:0] OP_HALT = 4'b0000;
   localparam logic [3:0] OP_BLT  = 4'b0100;
   localparam logic [3:0] OP_BGT  = 4'b0101;
   localparam logic [3:0] OP_BEQ  = 4'b0110;
   localparam logic [3:0] OP_JMP  = 4'b1100;

   // Value of the flush counter in the final squash cycle (two cycles total).
   localparam logic [1:0] FLUSH_LAST = 2'd1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   function automatic logic is_cond_br(input logic [3:0] op);
      return (op == OP_BLT) || (op == OP_BGT) || (op == OP_BEQ);
   endfunction

endpackage

// File: rtl/branch_ctrl.sv
// Fetch PC sequencer: resolves branches/jumps/halt from ID and squashes IF/ID for 2 cycles on redirect.
// Latency: decision to pc update is one edge; br only reaches pc through a register.
// Backpressure: stall holds pc/state/count in RUN; ignored while flushing; HALT exits only by reset.
module branch_ctrl
   import cups_pkg::*;
#(
   parameter int PC_W = PC_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [3:0]      id_op,
   input  logic [PC_W-1:0] id_pc,
   input  logic [7:0]      id_off,
   input  logic [PC_W-1:0] jmp_tgt,
   input  logic            br,
   input  logic            stall,
   output logic [PC_W-1:0] pc,
   output logic            if_en,
   output logic            flush,
   output logic            busy,
   output logic [15:0]     tkn_cnt
);

   state_t          state, state_d;
   logic [1:0]      fcnt, fcnt_d;
   logic            started;
   logic            decide, is_jmp, redirect, halt_req;
   logic [PC_W-1:0] off_ext, br_tgt, pc_d;

   // started is low only during the first cycle out of reset, when pc=0 is being fetched.
   assign decide   = (state == ST_RUN) && started && !stall && id_valid;
   assign is_jmp   = (id_op == OP_JMP);
   assign redirect = decide && (is_jmp || (is_cond_br(id_op) && br));
   assign halt_req = decide && (id_op == OP_HALT);
   assign off_ext  = {{(PC_W-8){id_off[7]}}, id_off};
   assign br_tgt   = id_pc + {{(PC_W-1){1'b0}}, 1'b1} + off_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_RUN;
         fcnt    <= 2'd0;
         started <= 1'b0;
      end else begin
         state   <= state_d;
         fcnt    <= fcnt_d;
         started <= 1'b1;
      end
   end

   always_comb begin
      state_d = state;
      fcnt_d  = fcnt;
      case (state)
         ST_RUN: begin
            if (redirect) begin
               state_d = ST_FLUSH;
               fcnt_d  = 2'd0;
            end else if (halt_req) begin
               state_d = ST_HALT;
            end
         end
         ST_FLUSH: begin
            if (fcnt == FLUSH_LAST) begin
               state_d = ST_RUN;
               fcnt_d  = 2'd0;
            end else begin
               fcnt_d = fcnt + 2'd1;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      busy  = (state != ST_RUN);
      flush = (state == ST_FLUSH);
      if_en = started && (state != ST_HALT);
   end

   always_comb begin
      pc_d = pc;
      case (state)
         ST_RUN: begin
            if (started && !stall) begin
               if (redirect) pc_d = is_jmp ? jmp_tgt : br_tgt;
               else          pc_d = pc + {{(PC_W-1){1'b0}}, 1'b1};
            end
         end
         ST_FLUSH: pc_d = pc + {{(PC_W-1){1'b0}}, 1'b1};
         default:  pc_d = pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= '0;
         tkn_cnt <= 16'd0;
      end else begin
         pc <= pc_d;
         if (redirect && (tkn_cnt != 16'hFFFF)) tkn_cnt <= tkn_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed vector table, mid-flush reset sequence, random run against a reference model.
module tb_branch_ctrl;
   import cups_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [3:0]  id_op = 4'h1;
   logic [15:0] id_pc = '0;
   logic [7:0]  id_off = '0;
   logic [15:0] jmp_tgt = '0;
   logic        br = 1'b0;
   logic        stall = 1'b0;
   logic [15:0] pc;
   logic        if_en, flush, busy;
   logic [15:0] tkn_cnt;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   branch_ctrl #(.PC_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_pc(id_pc),
      .id_off(id_off), .jmp_tgt(jmp_tgt), .br(br), .stall(stall),
      .pc(pc), .if_en(if_en), .flush(flush), .busy(busy), .tkn_cnt(tkn_cnt)
   );

   typedef struct {
      logic        vld;
      logic [3:0]  op;
      logic [15:0] ipc;
      logic [7:0]  off;
      logic [15:0] tgt;
      logic        b;
      logic        st;
      logic [15:0] e_pc;
      logic        e_fl;
      logic        e_busy;
      logic        e_if;
      logic [15:0] e_tkn;
   } vec_t;

   vec_t tbl[27];

   function automatic vec_t mk(logic vld, logic [3:0] op, logic [15:0] ipc, logic [7:0] off,
                               logic [15:0] tgt, logic b, logic st, logic [15:0] e_pc,
                               logic e_fl, logic e_busy, logic e_if, logic [15:0] e_tkn);
      return '{vld, op, ipc, off, tgt, b, st, e_pc, e_fl, e_busy, e_if, e_tkn};
   endfunction

   function automatic vec_t idl(logic [15:0] e_pc, logic e_fl, logic e_busy, logic e_if,
                                logic [15:0] e_tkn);
      return mk(1'b0, 4'h1, 16'h0, 8'h0, 16'h0, 1'b0, 1'b0, e_pc, e_fl, e_busy, e_if, e_tkn);
   endfunction

   task automatic chk(input string name, input logic [15:0] e_pc, input logic e_fl,
                      input logic e_busy, input logic e_if, input logic [15:0] e_tkn);
      n_chk++;
      if (pc === e_pc && flush === e_fl && busy === e_busy && if_en === e_if && tkn_cnt === e_tkn)
         n_pass++;
      else
         $display("FAIL %s: got pc=%h flush=%b busy=%b if_en=%b tkn=%0d, expected pc=%h flush=%b busy=%b if_en=%b tkn=%0d",
                  name, pc, flush, busy, if_en, tkn_cnt, e_pc, e_fl, e_busy, e_if, e_tkn);
   endtask

   task automatic drive(input logic vld, input logic [3:0] op, input logic [15:0] ipc,
                        input logic [7:0] off, input logic [15:0] tgt, input logic b, input logic st);
      id_valid = vld; id_op = op; id_pc = ipc; id_off = off; jmp_tgt = tgt; br = b; stall = st;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reference model: plain counters and flags describing the observable behaviour.
   logic [15:0] m_pc, m_tkn;
   int          m_fl;
   bit          m_halt, m_start;

   task automatic m_reset;
      m_pc = 16'h0; m_tkn = 16'h0; m_fl = 0; m_halt = 0; m_start = 0;
   endtask

   task automatic m_edge;
      if (m_halt) return;
      if (!m_start) begin m_start = 1; return; end
      if (m_fl > 0) begin m_pc = m_pc + 16'd1; m_fl--; return; end
      if (stall) return;
      if (id_valid && (id_op == 4'b1100 || (id_op inside {4'b0100, 4'b0101, 4'b0110} && br))) begin
         if (id_op == 4'b1100) m_pc = jmp_tgt;
         else                  m_pc = 16'(int'(id_pc) + 1 + int'($signed(id_off)));
         m_fl = 2;
         if (m_tkn != 16'hFFFF) m_tkn = m_tkn + 16'd1;
      end else begin
         m_pc = m_pc + 16'd1;
         if (id_valid && id_op == 4'b0000) m_halt = 1;
      end
   endtask

   initial begin
      tbl[0]  = idl(16'h0000, 0, 0, 1, 0);
      tbl[1]  = idl(16'h0001, 0, 0, 1, 0);
      tbl[2]  = idl(16'h0002, 0, 0, 1, 0);
      tbl[3]  = idl(16'h0003, 0, 0, 1, 0);
      tbl[4]  = idl(16'h0004, 0, 0, 1, 0);
      tbl[5]  = mk(1, OP_BGT, 16'h0010, 8'hFE, 16'h0, 1, 0, 16'h000F, 1, 1, 1, 1);
      tbl[6]  = idl(16'h0010, 1, 1, 1, 1);
      tbl[7]  = idl(16'h0011, 0, 0, 1, 1);
      tbl[8]  = mk(1, OP_BEQ, 16'h0011, 8'h05, 16'h0, 0, 0, 16'h0012, 0, 0, 1, 1);
      tbl[9]  = mk(0, OP_JMP, 16'h0, 8'h0, 16'h9999, 0, 0, 16'h0013, 0, 0, 1, 1);
      tbl[10] = mk(1, OP_JMP, 16'h0, 8'h0, 16'h1234, 1, 1, 16'h0013, 0, 0, 1, 1);
      tbl[11] = mk(1, OP_JMP, 16'h0, 8'h0, 16'h1234, 1, 1, 16'h0013, 0, 0, 1, 1);
      tbl[12] = mk(1, OP_JMP, 16'h0, 8'h0, 16'h1234, 1, 1, 16'h0013, 0, 0, 1, 1);
      tbl[13] = mk(1, OP_JMP, 16'h0, 8'h0, 16'h1234, 0, 0, 16'h1234, 1, 1, 1, 2);
      tbl[14] = mk(1, OP_JMP, 16'h0, 8'h0, 16'h5555, 0, 1, 16'h1235, 1, 1, 1, 2);
      tbl[15] = mk(1, OP_BLT, 16'h0, 8'h10, 16'h0, 1, 1, 16'h1236, 0, 0, 1, 2);
      tbl[16] = mk(1, OP_JMP, 16'h0, 8'h0, 16'hFFFD, 0, 0, 16'hFFFD, 1, 1, 1, 3);
      tbl[17] = idl(16'hFFFE, 1, 1, 1, 3);
      tbl[18] = idl(16'hFFFF, 0, 0, 1, 3);
      tbl[19] = idl(16'h0000, 0, 0, 1, 3);
      tbl[20] = mk(1, OP_BLT, 16'h7FF0, 8'h7F, 16'h0, 1, 0, 16'h8070, 1, 1, 1, 4);
      tbl[21] = idl(16'h8071, 1, 1, 1, 4);
      tbl[22] = idl(16'h8072, 0, 0, 1, 4);
      tbl[23] = mk(1, OP_HALT, 16'h0, 8'h0, 16'h0, 0, 1, 16'h8072, 0, 0, 1, 4);
      tbl[24] = mk(1, OP_HALT, 16'h0, 8'h0, 16'h0, 0, 0, 16'h8073, 0, 1, 0, 4);
      tbl[25] = mk(1, OP_JMP, 16'h0, 8'h0, 16'h1234, 0, 0, 16'h8073, 0, 1, 0, 4);
      tbl[26] = idl(16'h8073, 0, 1, 0, 4);

      #12;
      chk("reset", 16'h0, 0, 0, 0, 16'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].vld, tbl[i].op, tbl[i].ipc, tbl[i].off, tbl[i].tgt, tbl[i].b, tbl[i].st);
         step();
         chk($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fl, tbl[i].e_busy, tbl[i].e_if, tbl[i].e_tkn);
      end

      // Asynchronous reset landing in the second flush cycle.
      drive(0, 4'h1, 16'h0, 8'h0, 16'h0, 0, 0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
      chk("mf_start", 16'h0000, 0, 0, 1, 16'h0);
      drive(1, OP_JMP, 16'h0, 8'h0, 16'h0040, 0, 0);
      step();
      chk("mf_jump", 16'h0040, 1, 1, 1, 16'h1);
      drive(0, 4'h1, 16'h0, 8'h0, 16'h0, 0, 0);
      step();
      chk("mf_flush2", 16'h0041, 1, 1, 1, 16'h1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mf_async_rst", 16'h0000, 0, 0, 0, 16'h0);
      #1;
      rst_n = 1'b1;
      step();
      chk("mf_restart", 16'h0000, 0, 0, 1, 16'h0);
      step();
      chk("mf_run", 16'h0001, 0, 0, 1, 16'h0);

      // Random run against the reference model, with periodic resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 250 == 0) begin
            rst_n = 1'b0;
            #1;
            m_reset();
            chk("rand_rst", m_pc, m_fl > 0, (m_fl > 0) || m_halt, m_start && !m_halt, m_tkn);
            rst_n = 1'b1;
         end
         begin
            logic [3:0] op;
            int r;
            r = $urandom_range(0, 999);
            if (r < 3)        op = OP_HALT;
            else if (r < 300) op = 4'($urandom_range(4, 6));
            else if (r < 450) op = OP_JMP;
            else begin
               op = 4'($urandom_range(0, 15));
               if (op inside {4'h0, 4'h4, 4'h5, 4'h6, 4'hC}) op = 4'h7;
            end
            drive($urandom_range(0, 9) < 7, op, 16'($urandom), 8'($urandom), 16'($urandom),
                  1'($urandom), $urandom_range(0, 3) == 0);
         end
         m_edge();
         step();
         chk("rand", m_pc, m_fl > 0, (m_fl > 0) || m_halt, m_start && !m_halt, m_tkn);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
